// File: rtl/quota_arbiter_pkg.sv
// Shared types and constant helpers for the quota arbiter.
// The FSM state encoding and width helpers are used by the top and the selector.
package quota_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // Gap lengths run 0..15, so a fixed 4-bit counter always suffices.
  localparam int GAP_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int value);
    return (value < 1) ? 1 : value;
  endfunction

endpackage

// File: rtl/quota_arbiter_rr_select.sv
// Rotating priority encoder: the first set request at or after the pointer,
// wrapping from the top index back to zero.
module quota_arbiter_rr_select #(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] request,
  input  logic [IDX_W-1:0]     pointer,
  output logic [NUM_PORTS-1:0] pick,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  localparam int PW = IDX_W + 1;

  logic [PW-1:0] pos;

  // Scan from the farthest slot down so the nearest one to the pointer wins.
  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      pos = {1'b0, pointer} + PW'(k);
      if (pos >= PW'(NUM_PORTS)) pos = pos - PW'(NUM_PORTS);
      if (request[pos[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      pick[i] = valid && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/quota_arbiter.sv
// Round-robin arbiter with a per-grant hold quota and a bus turnaround gap.
// Owner keeps the resource while requesting; it is preempted after MAX_HOLD if others wait.
module quota_arbiter
  import quota_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 3,
  parameter  int MAX_HOLD  = 16,
  parameter  int GAP       = 1,
  localparam int OWN_W     = max1(clog2(NUM_PORTS))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] request,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 active,
  output logic [OWN_W-1:0]     owner,
  output logic                 preempt
);

  localparam int               HOLD_W    = max1(clog2(MAX_HOLD + 1));
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
  localparam logic [OWN_W-1:0]  LAST_PORT = OWN_W'(NUM_PORTS - 1);

  arb_state_e           state;
  logic [OWN_W-1:0]     pointer;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic [NUM_PORTS-1:0] pick;
  logic [OWN_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic                 owner_req;
  logic                 others_req;
  logic                 quota_hit;
  logic [OWN_W-1:0]     next_ptr;

  quota_arbiter_rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (OWN_W)
  ) u_rr_select (
    .request (request),
    .pointer (pointer),
    .pick    (pick),
    .idx     (pick_idx),
    .valid   (pick_vld)
  );

  assign owner_req  = request[owner];
  assign others_req = |(request & ~grant);
  assign quota_hit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
  assign next_ptr   = (owner == LAST_PORT) ? '0 : owner + 1'b1;
  assign active     = |grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      owner    <= '0;
      preempt  <= 1'b0;
      pointer  <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant    <= pick;
            owner    <= pick_idx;
            hold_cnt <= HOLD_W'(1);
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A release while the owner still requests can only be the quota firing.
          if (!owner_req || (quota_hit && others_req)) begin
            grant    <= '0;
            preempt  <= owner_req;
            pointer  <= next_ptr;
            hold_cnt <= '0;
            gap_cnt  <= GAP_LOAD;
            state    <= (GAP > 0) ? ST_GAP : ST_IDLE;
          end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quota_arbiter.sv
// Directed and random checks of quota_arbiter on three parameterisations.
module tb_quota_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] req_a, req_b, req_c;
  logic [2:0] grant_a, grant_b, grant_c;
  logic       active_a, active_b, active_c;
  logic [1:0] owner_a, owner_b, owner_c;
  logic       preempt_a, preempt_b, preempt_c;

  int checks = 0;
  int errors = 0;

  quota_arbiter #(.NUM_PORTS(3), .MAX_HOLD(4), .GAP(1)) dut (
    .clk(clk), .rst(rst), .request(req_a), .grant(grant_a),
    .active(active_a), .owner(owner_a), .preempt(preempt_a)
  );

  quota_arbiter #(.NUM_PORTS(3), .MAX_HOLD(0), .GAP(2)) dut_nolim (
    .clk(clk), .rst(rst), .request(req_b), .grant(grant_b),
    .active(active_b), .owner(owner_b), .preempt(preempt_b)
  );

  quota_arbiter #(.NUM_PORTS(3), .MAX_HOLD(16), .GAP(1)) dut_long (
    .clk(clk), .rst(rst), .request(req_c), .grant(grant_c),
    .active(active_c), .owner(owner_c), .preempt(preempt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected sequence for request=111 held on the MAX_HOLD=4, GAP=1 instance.
  logic [2:0] exp_g [25] = '{
    3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000,
    3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000,
    3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000,
    3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000,
    3'b010
  };
  logic exp_p [25] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
    1'b0
  };
  logic [1:0] exp_o [25] = '{
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
    2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
    2'd1
  };

  logic [2:0] nxt;
  logic [2:0] prev;
  logic [2:0] last_grant;
  int         wait_cnt [3];
  int         maxw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    step();
    step();
    chk("rst_grant", grant_a, 3'b000);
    chk("rst_active", active_a, 1'b0);
    chk("rst_owner", owner_a, 2'd0);
    chk("rst_preempt", preempt_a, 1'b0);
    chk("rst_grant_b", grant_b, 3'b000);
    chk("rst_grant_c", grant_c, 3'b000);

    // All three ports contend: quota handovers with rotating priority.
    rst   = 1'b1;
    req_a = 3'b111;
    for (int s = 0; s < 25; s++) begin
      step();
      chk($sformatf("rr_grant[%0d]", s + 1), grant_a, exp_g[s]);
      chk($sformatf("rr_preempt[%0d]", s + 1), preempt_a, exp_p[s]);
      chk($sformatf("rr_owner[%0d]", s + 1), owner_a, exp_o[s]);
      chk($sformatf("rr_active[%0d]", s + 1), active_a, |exp_g[s]);
    end

    // Asynchronous reset in the middle of port1's grant.
    #3 rst = 1'b0;
    #1;
    chk("async_grant", grant_a, 3'b000);
    chk("async_active", active_a, 1'b0);
    chk("async_owner", owner_a, 2'd0);
    chk("async_preempt", preempt_a, 1'b0);
    step();
    chk("held_rst_grant", grant_a, 3'b000);
    rst = 1'b1;
    step();
    chk("post_rst_grant", grant_a, 3'b001);
    chk("post_rst_owner", owner_a, 2'd0);
    req_a = 3'b000;
    step();
    chk("drop_grant", grant_a, 3'b000);
    chk("drop_preempt", preempt_a, 1'b0);
    step();
    step();

    // Voluntary release by a lone requester.
    req_a = 3'b010;
    for (int s = 0; s < 3; s++) begin
      step();
      chk($sformatf("vol_grant[%0d]", s + 2), grant_a, 3'b010);
      chk($sformatf("vol_preempt[%0d]", s + 2), preempt_a, 1'b0);
    end
    req_a = 3'b000;
    step();
    chk("vol_release", grant_a, 3'b000);
    chk("vol_release_preempt", preempt_a, 1'b0);
    chk("vol_owner_kept", owner_a, 2'd1);
    step();

    // Lone requester well past MAX_HOLD keeps the grant.
    req_c = 3'b100;
    for (int s = 0; s < 40; s++) begin
      step();
      chk($sformatf("solo_grant[%0d]", s), grant_c, 3'b100);
      chk($sformatf("solo_preempt[%0d]", s), preempt_c, 1'b0);
    end
    req_c = 3'b000;
    step();
    chk("solo_release", grant_c, 3'b000);

    // MAX_HOLD=0: no quota even with a waiting port.
    req_b = 3'b001;
    step();
    chk("nolim_first", grant_b, 3'b001);
    req_b = 3'b011;
    for (int s = 0; s < 100; s++) begin
      step();
      chk($sformatf("nolim_hold[%0d]", s), grant_b, 3'b001);
      chk($sformatf("nolim_preempt[%0d]", s), preempt_b, 1'b0);
    end
    req_b = 3'b010;
    step();
    chk("nolim_release", grant_b, 3'b000);
    chk("nolim_rel_preempt", preempt_b, 1'b0);
    step();
    chk("nolim_gap1", grant_b, 3'b000);
    step();
    chk("nolim_idle", grant_b, 3'b000);
    step();
    chk("nolim_next_grant", grant_b, 3'b010);
    chk("nolim_next_owner", owner_b, 2'd1);
    req_b = 3'b000;

    // Random requests: one-hot, grant follows request, bounded wait.
    step();
    step();
    step();
    prev       = '0;
    last_grant = grant_a;
    for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (req_a[i]) nxt[i] = ($urandom_range(7) != 0);
        else          nxt[i] = ($urandom_range(3) == 0);
      end
      req_a = nxt;
      prev  = nxt;
      step();
      chk("rand_onehot", $onehot0(grant_a), 1'b1);
      chk("rand_grant_req", grant_a & ~prev, 3'b000);
      maxw = 0;
      for (int i = 0; i < 3; i++) begin
        if (prev[i] && !grant_a[i] && !last_grant[i]) wait_cnt[i] = wait_cnt[i] + 1;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
      end
      chk("rand_wait_bound", (maxw <= 13), 1'b1);
      last_grant = grant_a;
    end
    req_a = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
